// File: rtl/ifc_z_accum.sv
// ifc_z_accum: sums windows of NSAMP unsigned interface Z samples and hands
// each window total downstream with a valid/ready handshake.
// A window closes when NSAMP samples have been taken, or earlier on FLUSH.
// The block refuses new samples while a finished sum waits for SUM_READY.
// Optional feature macro: IFC_ACCUM_SAT_EN
//   defined   -> the accumulator saturates at 2^WOUT-1 and OVF reports it
//   undefined -> the accumulator wraps modulo 2^WOUT and OVF is tied to 0
//
// state     | meaning
// ST_ACCUM  | taking samples into the open window (Z_READY=1)
// ST_HOLD   | window total on SUM, waiting for SUM_READY (Z_READY=0)

module ifc_z_accum #(
  parameter int NX    = 16,
  parameter int NSAMP = 4,
  parameter int WOUT  = 24
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NX-1:0]              IFC_Z,
  input  logic                       Z_VALID,
  output logic                       Z_READY,
  input  logic                       FLUSH,
  output logic [WOUT-1:0]            SUM,
  output logic                       SUM_VALID,
  input  logic                       SUM_READY,
  output logic [$clog2(NSAMP+1)-1:0] COUNT,
  output logic                       OVF
);

  localparam int CW = $clog2(NSAMP+1);

  typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [WOUT-1:0] r_acc;
  logic [CW-1:0]   r_count;
  logic [WOUT-1:0] r_sum;
  logic            r_sum_valid;

  logic            w_accept;
  logic            w_close;
  logic [WOUT-1:0] w_z_ext;
  logic [WOUT-1:0] w_acc_add;
  logic [WOUT-1:0] w_acc_next;
  logic [CW-1:0]   w_count_inc;

  assign w_accept    = Z_VALID && (r_state == ST_ACCUM);
  assign w_z_ext     = WOUT'(IFC_Z);
  assign w_acc_next  = w_accept ? w_acc_add : r_acc;
  assign w_count_inc = r_count + CW'(1);

  // A sample taken together with FLUSH still belongs to the closing window,
  // so an empty window is only skipped when nothing arrives with the FLUSH.
  assign w_close = (r_state == ST_ACCUM) &&
                   ((w_accept && (w_count_inc == CW'(NSAMP))) ||
                    (FLUSH && (w_accept || (r_count != '0))));

`ifdef IFC_ACCUM_SAT_EN
  logic            r_ovf;
  logic            r_ovf_sticky;
  logic [WOUT:0]   w_sum_full;
  logic            w_carry;
  logic            w_ovf_next;

  assign w_sum_full = {1'b0, r_acc} + {1'b0, w_z_ext};
  assign w_carry    = w_sum_full[WOUT];
  assign w_acc_add  = w_carry ? '1 : w_sum_full[WOUT-1:0];
  assign w_ovf_next = r_ovf_sticky | (w_accept & w_carry);
  assign OVF        = r_ovf;

  // Overflow flags: sticky per open window, latched into OVF at close.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ovf        <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else if (w_close) begin
      r_ovf        <= w_ovf_next;
      r_ovf_sticky <= 1'b0;
    end else if (r_state == ST_HOLD) begin
      if (SUM_READY) r_ovf <= 1'b0;
    end else begin
      r_ovf_sticky <= w_ovf_next;
    end
  end
`else
  assign w_acc_add = r_acc + w_z_ext;
  assign OVF       = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_ACCUM;
    else     r_state <= w_state_next;
  end

  // Next-state and Z_READY decode.
  always_comb begin
    w_state_next = r_state;
    Z_READY      = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        Z_READY = 1'b1;
        if (w_close) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (SUM_READY) w_state_next = ST_ACCUM;
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  // Accumulator, sample count and the held window result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else if (w_close) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_sum       <= w_acc_next;
      r_sum_valid <= 1'b1;
    end else if (r_state == ST_HOLD) begin
      if (SUM_READY) r_sum_valid <= 1'b0;
    end else begin
      r_acc <= w_acc_next;
      if (w_accept) r_count <= w_count_inc;
    end
  end

  assign SUM       = r_sum;
  assign SUM_VALID = r_sum_valid;
  assign COUNT     = r_count;

endmodule

// File: tb/tb_ifc_z_accum.sv
// Directed bench for ifc_z_accum. Two instances share all inputs: one with
// the default widths, one with WOUT=17 for the overflow case.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.

module tb_ifc_z_accum;

  localparam int NX    = 16;
  localparam int NSAMP = 4;
  localparam int CW    = $clog2(NSAMP+1);

  logic          CLK = 1'b0;
  logic          RST;
  logic [NX-1:0] IFC_Z;
  logic          Z_VALID;
  logic          FLUSH;
  logic          SUM_READY;

  logic          z_ready_a,  sum_valid_a, ovf_a;
  logic [23:0]   sum_a;
  logic [CW-1:0] count_a;
  logic          z_ready_s,  sum_valid_s, ovf_s;
  logic [16:0]   sum_s;
  logic [CW-1:0] count_s;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  ifc_z_accum #(.NX(NX), .NSAMP(NSAMP), .WOUT(24)) dut (
    .CLK(CLK), .RST(RST), .IFC_Z(IFC_Z), .Z_VALID(Z_VALID), .Z_READY(z_ready_a),
    .FLUSH(FLUSH), .SUM(sum_a), .SUM_VALID(sum_valid_a), .SUM_READY(SUM_READY),
    .COUNT(count_a), .OVF(ovf_a)
  );

  ifc_z_accum #(.NX(NX), .NSAMP(NSAMP), .WOUT(17)) dut_s (
    .CLK(CLK), .RST(RST), .IFC_Z(IFC_Z), .Z_VALID(Z_VALID), .Z_READY(z_ready_s),
    .FLUSH(FLUSH), .SUM(sum_s), .SUM_VALID(sum_valid_s), .SUM_READY(SUM_READY),
    .COUNT(count_s), .OVF(ovf_s)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [NX-1:0] v);
    Z_VALID = 1'b1;
    IFC_Z   = v;
    tick();
    Z_VALID = 1'b0;
    IFC_Z   = '0;
  endtask

  task automatic release_sum();
    SUM_READY = 1'b1;
    tick();
    SUM_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; Z_VALID = 1'b1; IFC_Z = 16'd7; FLUSH = 1'b0; SUM_READY = 1'b0;
    tick();
    tick();
    checks++;
    if (count_a !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_a); end
    checks++;
    if (sum_valid_a !== 1'b0 || sum_a !== 24'd0 || ovf_a !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got valid=%b sum=%0d ovf=%b exp valid=0 sum=0 ovf=0", sum_valid_a, sum_a, ovf_a);
    end
    checks++;
    if (z_ready_a !== 1'b1) begin failures++; $display("FAIL reset_zready got=%b exp=1", z_ready_a); end
    RST = 1'b0; Z_VALID = 1'b0; IFC_Z = '0;
  endtask

  task automatic test_full_window();
    send(16'd1);
    send(16'd2);
    send(16'd3);
    checks++;
    if (count_a !== 3'd3 || sum_valid_a !== 1'b0) begin
      failures++; $display("FAIL full_partial got count=%0d valid=%b exp count=3 valid=0", count_a, sum_valid_a);
    end
    send(16'd4);
    checks++;
    if (sum_valid_a !== 1'b1 || sum_a !== 24'd10 || ovf_a !== 1'b0 || count_a !== 3'd0) begin
      failures++; $display("FAIL full_sum got valid=%b sum=%0d ovf=%b count=%0d exp 1/10/0/0", sum_valid_a, sum_a, ovf_a, count_a);
    end
  endtask

  task automatic test_backpressure();
    // Samples and FLUSH offered while the sum is held must be ignored.
    Z_VALID = 1'b1; IFC_Z = 16'd99; FLUSH = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sum_valid_a !== 1'b1 || sum_a !== 24'd10 || z_ready_a !== 1'b0) begin
        failures++; $display("FAIL hold_cycle%0d got valid=%b sum=%0d zready=%b exp 1/10/0", i, sum_valid_a, sum_a, z_ready_a);
      end
      tick();
    end
    Z_VALID = 1'b0; IFC_Z = '0; FLUSH = 1'b0;
    release_sum();
    checks++;
    if (z_ready_a !== 1'b1 || sum_valid_a !== 1'b0 || count_a !== 3'd0) begin
      failures++; $display("FAIL hold_release got zready=%b valid=%b count=%0d exp 1/0/0", z_ready_a, sum_valid_a, count_a);
    end
  endtask

  task automatic test_flush();
    send(16'd5);
    send(16'd7);
    Z_VALID = 1'b1; IFC_Z = 16'd9; FLUSH = 1'b1;
    tick();
    Z_VALID = 1'b0; IFC_Z = '0; FLUSH = 1'b0;
    checks++;
    if (sum_valid_a !== 1'b1 || sum_a !== 24'd21 || count_a !== 3'd0) begin
      failures++; $display("FAIL flush_sum got valid=%b sum=%0d count=%0d exp 1/21/0", sum_valid_a, sum_a, count_a);
    end
    release_sum();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    checks++;
    if (sum_valid_a !== 1'b0 || z_ready_a !== 1'b1) begin
      failures++; $display("FAIL flush_empty got valid=%b zready=%b exp 0/1", sum_valid_a, z_ready_a);
    end
    tick();
    checks++;
    if (sum_valid_a !== 1'b0) begin failures++; $display("FAIL flush_empty_late got valid=%b exp 0", sum_valid_a); end
  endtask

  task automatic test_saturation();
    logic [16:0] exp_sum;
    logic        exp_ovf;
`ifdef IFC_ACCUM_SAT_EN
    exp_sum = 17'h1FFFF; exp_ovf = 1'b1;
`else
    exp_sum = 17'h1FFFC; exp_ovf = 1'b0;
`endif
    for (int i = 0; i < 4; i++) send(16'hFFFF);
    checks++;
    if (sum_valid_s !== 1'b1 || sum_s !== exp_sum || ovf_s !== exp_ovf) begin
      failures++; $display("FAIL sat_narrow got valid=%b sum=%h ovf=%b exp 1/%h/%b", sum_valid_s, sum_s, ovf_s, exp_sum, exp_ovf);
    end
    checks++;
    if (sum_a !== 24'h03FFFC || ovf_a !== 1'b0) begin
      failures++; $display("FAIL sat_wide got sum=%h ovf=%b exp 03fffc/0", sum_a, ovf_a);
    end
    release_sum();
    send(16'd1);
    Z_VALID = 1'b1; IFC_Z = 16'd1; FLUSH = 1'b1;
    tick();
    Z_VALID = 1'b0; IFC_Z = '0; FLUSH = 1'b0;
    checks++;
    if (sum_valid_s !== 1'b1 || sum_s !== 17'd2 || ovf_s !== 1'b0) begin
      failures++; $display("FAIL sat_next_window got valid=%b sum=%0d ovf=%b exp 1/2/0", sum_valid_s, sum_s, ovf_s);
    end
    release_sum();
  endtask

  task automatic test_reset_mid();
    send(16'd3);
    send(16'd3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (count_a !== 3'd0 || sum_valid_a !== 1'b0) begin
      failures++; $display("FAIL rstmid_clear got count=%0d valid=%b exp 0/0", count_a, sum_valid_a);
    end
    for (int i = 0; i < 3; i++) begin
      send(16'd1);
      checks++;
      if (sum_valid_a !== 1'b0) begin failures++; $display("FAIL rstmid_early%0d got valid=%b exp 0", i, sum_valid_a); end
    end
    send(16'd1);
    checks++;
    if (sum_valid_a !== 1'b1 || sum_a !== 24'd4) begin
      failures++; $display("FAIL rstmid_sum got valid=%b sum=%0d exp 1/4", sum_valid_a, sum_a);
    end
    release_sum();
  endtask

  task automatic test_gapped();
    logic [NX-1:0] vals [4];
    vals[0] = 16'd2; vals[1] = 16'd4; vals[2] = 16'd6; vals[3] = 16'd8;
    for (int i = 0; i < 3; i++) begin
      send(vals[i]);
      tick();
      checks++;
      if (count_a !== CW'(i + 1) || sum_valid_a !== 1'b0) begin
        failures++; $display("FAIL gap_count%0d got count=%0d valid=%b exp %0d/0", i, count_a, sum_valid_a, i + 1);
      end
    end
    send(vals[3]);
    checks++;
    if (sum_valid_a !== 1'b1 || sum_a !== 24'd20 || count_a !== 3'd0) begin
      failures++; $display("FAIL gap_sum got valid=%b sum=%0d count=%0d exp 1/20/0", sum_valid_a, sum_a, count_a);
    end
    release_sum();
  endtask

  initial begin
    test_reset();
    test_full_window();
    test_backpressure();
    test_flush();
    test_saturation();
    test_reset_mid();
    test_gapped();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifc_z_accum.md
IFC_Z_ACCUM -- requirements
Module: ifc_z_accum

Interface
REQ-001 SHALL have parameter NX, default 16: width of the incoming interface Z sample.
REQ-002 SHALL have parameter NSAMP, default 4: number of samples per window; legal range 2..256.
REQ-003 SHALL have parameter WOUT, default 24: accumulator and sum width; WOUT >= NX is required.
REQ-004 SHALL have port CLK, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port IFC_Z, input, NX bits: unsigned sample from the upstream interface stage.
REQ-007 SHALL have port Z_VALID, input, 1 bit: IFC_Z holds a valid sample.
REQ-008 SHALL have port Z_READY, output, 1 bit: the block accepts a sample this cycle.
REQ-009 SHALL have port FLUSH, input, 1 bit: close the current window early.
REQ-010 SHALL have port SUM, output, WOUT bits: the window sum.
REQ-011 SHALL have port SUM_VALID, output, 1 bit: SUM is valid.
REQ-012 SHALL have port SUM_READY, input, 1 bit: downstream accepts SUM.
REQ-013 SHALL have port COUNT, output, clog2(NSAMP+1) bits: number of samples accepted in the current window.
REQ-014 SHALL have port OVF, output, 1 bit: the emitted window overflowed.

Function
REQ-015 SHALL implement a two-state FSM: ACCUM and HOLD.
REQ-016 In ACCUM, Z_READY SHALL be 1; in HOLD, Z_READY SHALL be 0.
REQ-017 A sample SHALL be accepted when Z_VALID and Z_READY are both high; on acceptance, the accumulator adds zero-extended IFC_Z and COUNT increments.
REQ-018 When the accepted sample makes COUNT equal NSAMP, the block SHALL load SUM with the final total, assert SUM_VALID on the next cycle, clear the accumulator and COUNT, and enter HOLD.
REQ-019 FLUSH in ACCUM with COUNT > 0 SHALL close the window the same way; a sample accepted in the same cycle is included in the window.
REQ-020 FLUSH with COUNT = 0 and no sample accepted SHALL be ignored; FLUSH in HOLD SHALL be ignored.
REQ-021 In HOLD, SUM, SUM_VALID and OVF SHALL stay stable until SUM_READY is high; the FSM then returns to ACCUM and SUM_VALID drops on the next cycle.
REQ-022 Latency from acceptance of the closing sample to SUM_VALID SHALL be exactly 1 cycle.
REQ-023 Minimum window-to-window gap SHALL be 1 cycle, the HOLD-to-ACCUM transition.
REQ-024 OVF SHALL be valid only while SUM_VALID is high; its behaviour is defined in Configuration.

Reset
REQ-025 While RST is high at a CLK edge, the FSM SHALL go to ACCUM, and the accumulator, COUNT, SUM, SUM_VALID and OVF SHALL go to 0.
REQ-026 Reset mid-window or in HOLD SHALL discard the partial sum or pending SUM without emitting it.
REQ-027 A sample presented in a reset cycle SHALL NOT be counted.

Configuration
REQ-028 Macro IFC_ACCUM_SAT_EN defined: any add that carries out of WOUT bits SHALL clamp the accumulator to 2^WOUT-1 and set a sticky window-overflow flag; OVF reports that flag with the emitted SUM, and the flag clears when the window closes.
REQ-029 Macro IFC_ACCUM_SAT_EN undefined: the accumulator SHALL wrap modulo 2^WOUT, and OVF SHALL be constant 0.

Verification
REQ-030 Full window (NSAMP=4, WOUT=24): samples 1,2,3,4 back-to-back -> one cycle after the 4th sample, SUM=10, SUM_VALID=1, OVF=0, COUNT=0.
REQ-031 Backpressure: SUM_READY held low for 3 cycles after SUM_VALID -> SUM stays 10 and Z_READY=0 for those cycles; SUM_READY=1 -> Z_READY=1 on the next cycle.
REQ-032 Flush: samples 5,7 then FLUSH together with sample 9 -> SUM=21; then FLUSH alone with COUNT=0 -> no SUM_VALID.
REQ-033 Saturation (WOUT=17, NX=16): four samples of 0xFFFF -> with IFC_ACCUM_SAT_EN, SUM=0x1FFFF and OVF=1; without it, SUM=0x1FFFC and OVF=0.
REQ-034 Reset mid-window: samples 3,3, then RST for 1 cycle, then samples 1,1,1,1 -> SUM=4 and no earlier SUM_VALID.
REQ-035 Gapped input: Z_VALID toggled every other cycle with samples 2,4,6,8 -> SUM=20 and COUNT steps 1,2,3 between the samples.
